signed_display_driver: RTL and testbench

Converts an 8-bit two's-complement result into a sign digit plus three decimal digits on a 4-digit common-anode seven-segment display. It is the output-side counterpart of the keypad input path: the input path turns keypresses into a signed byte, and this block turns a signed byte back into human-readable digits. It sits after the calculator's result mux, and the control FSM strobes it whenever the displayed operand or result changes. Conversion is sequential (shift-add-3, one bit per clock), and display scanning is time-multiplexed by a refresh counter.

---
 rtl/signed_display_driver.sv | 130 +++++++++++++
 tb/tb_signed_display_driver.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/signed_display_driver.sv
// Signed byte to sign + 3 decimal digits on a 4-digit common-anode 7-seg display.
// Shift-add-3 conversion runs one bit per clock; the scan mux runs continuously.
module signed_display_driver #(
  parameter int REFRESH_DIV = 50000
) (
  input  logic       Clock,
  input  logic       Clear,
  input  logic       load,
  input  logic [7:0] value,
  output logic       busy,
  output logic       done,
  output logic [6:0] HEX3,
  output logic [6:0] HEX2,
  output logic [6:0] HEX1,
  output logic [6:0] HEX0,
  output logic [3:0] AN,
  output logic [6:0] SEG
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CONV = 2'd1;
  localparam logic [1:0] S_UPD  = 2'd2;

  localparam logic [6:0] BLANK = 7'h7F;
  localparam logic [6:0] MINUS = 7'h3F;
  localparam logic [6:0] ZERO  = 7'h40;

  localparam int RW = $clog2(REFRESH_DIV);
  localparam logic [RW-1:0] RLAST = RW'(REFRESH_DIV - 1);

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h40;
      4'd1:    seg7 = 7'h79;
      4'd2:    seg7 = 7'h24;
      4'd3:    seg7 = 7'h30;
      4'd4:    seg7 = 7'h19;
      4'd5:    seg7 = 7'h12;
      4'd6:    seg7 = 7'h02;
      4'd7:    seg7 = 7'h78;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h10;
      default: seg7 = BLANK;
    endcase
  endfunction

  logic [1:0]    state;
  logic          neg;
  logic [7:0]    mag;
  logic [11:0]   bcd;
  logic [11:0]   bcd_adj;
  logic [2:0]    bit_cnt;
  logic [RW-1:0] rcnt;
  logic [1:0]    idx;

  // add-3 correction applied to each nibble before the shift
  always_comb begin
    bcd_adj = bcd;
    for (int n = 0; n < 3; n++)
      if (bcd[n*4 +: 4] >= 4'd5) bcd_adj[n*4 +: 4] = bcd[n*4 +: 4] + 4'd3;
  end

  assign busy = (state != S_IDLE);

  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      state   <= S_IDLE;
      neg     <= 1'b0;
      mag     <= '0;
      bcd     <= '0;
      bit_cnt <= '0;
      done    <= 1'b0;
      HEX3    <= BLANK;
      HEX2    <= BLANK;
      HEX1    <= BLANK;
      HEX0    <= ZERO;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: if (load) begin
          neg     <= value[7];
          mag     <= value[7] ? (~value + 8'd1) : value;
          bcd     <= '0;
          bit_cnt <= '0;
          state   <= S_CONV;
        end
        S_CONV: begin
          {bcd, mag} <= {bcd_adj[10:0], mag, 1'b0};
          bit_cnt    <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state <= S_UPD;
        end
        S_UPD: begin
          HEX3  <= neg ? MINUS : BLANK;
          HEX2  <= (bcd[11:8] == 4'd0) ? BLANK : seg7(bcd[11:8]);
          HEX1  <= (bcd[11:4] == 8'd0) ? BLANK : seg7(bcd[7:4]);
          HEX0  <= seg7(bcd[3:0]);
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // scan mux: free-running, independent of the converter
  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      rcnt <= '0;
      idx  <= '0;
    end else if (rcnt == RLAST) begin
      rcnt <= '0;
      idx  <= idx + 2'd1;
    end else begin
      rcnt <= rcnt + 1'b1;
    end
  end

  assign AN = ~(4'b0001 << idx);

  always_comb begin
    SEG = HEX0;
    case (idx)
      2'd1:    SEG = HEX1;
      2'd2:    SEG = HEX2;
      2'd3:    SEG = HEX3;
      default: SEG = HEX0;
    endcase
  end

endmodule

// File: tb/tb_signed_display_driver.sv
// Bench for signed_display_driver: vector table, random loads vs arithmetic model,
// timing/ignore/abort sequences, and a continuous scan monitor.
module tb_signed_display_driver;

  localparam int RDIV = 4;

  logic       Clock = 1'b0;
  logic       Clear = 1'b0;
  logic       load  = 1'b0;
  logic [7:0] value = 8'h00;
  logic       busy, done;
  logic [6:0] HEX3, HEX2, HEX1, HEX0, SEG;
  logic [3:0] AN;

  signed_display_driver #(.REFRESH_DIV(RDIV)) dut (
    .Clock(Clock), .Clear(Clear), .load(load), .value(value),
    .busy(busy), .done(done),
    .HEX3(HEX3), .HEX2(HEX2), .HEX1(HEX1), .HEX0(HEX0),
    .AN(AN), .SEG(SEG)
  );

  always #5 Clock = ~Clock;

  int tests = 0;
  int fails = 0;

  localparam logic [27:0] RST_DISP = {7'h7F, 7'h7F, 7'h7F, 7'h40};
  logic [27:0] mdisp = RST_DISP;   // expected {HEX3,HEX2,HEX1,HEX0}
  int cyc = 0;                     // edges since reset release

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // digit encodings, written out independently of the DUT
  function automatic logic [6:0] dig(input int d);
    logic [6:0] t [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    return t[d];
  endfunction

  function automatic logic [27:0] model(input logic [7:0] v);
    int s, m, h, t, o;
    s = int'($signed(v));
    m = (s < 0) ? -s : s;
    h = m / 100;
    t = (m / 10) % 10;
    o = m % 10;
    return {(s < 0) ? 7'h3F : 7'h7F,
            (h == 0) ? 7'h7F : dig(h),
            (h == 0 && t == 0) ? 7'h7F : dig(t),
            dig(o)};
  endfunction

  always @(posedge Clock or negedge Clear)
    if (!Clear) cyc <= 0; else cyc <= cyc + 1;

  // scan monitor: digit index advances every RDIV cycles
  always @(negedge Clock) begin
    automatic int i = (cyc / RDIV) % 4;
    automatic logic [3:0] an_exp = 4'hF;
    an_exp[i] = 1'b0;
    chk("scan_AN", {28'h0, AN}, {28'h0, an_exp});
    chk("scan_SEG", {25'h0, SEG}, {25'h0, mdisp[i*7 +: 7]});
  end

  // Load v (sampled at the next edge k); checks busy/done through k+9.
  // Extra load pulses of 8'hFF are sampled at edges k+i for each set mask bit.
  task automatic run(input logic [7:0] v, input logic [27:0] exp, input logic [9:0] mask);
    load = 1'b1; value = v;
    @(posedge Clock); #1;
    load = 1'b0; value = ~v;
    chk("busy_k", {31'h0, busy}, 32'd1);
    chk("done_k", {31'h0, done}, 32'd0);
    for (int i = 1; i <= 9; i++) begin
      if (mask[i]) begin load = 1'b1; value = 8'hFF; end
      @(posedge Clock); #1;
      load = 1'b0;
      if (i < 9) begin
        chk("busy_conv", {31'h0, busy}, 32'd1);
        chk("done_conv", {31'h0, done}, 32'd0);
      end
    end
    mdisp = exp;
    chk("busy_k9", {31'h0, busy}, 32'd0);
    chk("done_k9", {31'h0, done}, 32'd1);
    chk($sformatf("hex_%h", v), {4'h0, HEX3, HEX2, HEX1, HEX0}, {4'h0, exp});
  endtask

  typedef struct {
    logic [7:0]  v;
    logic [27:0] exp;
  } vec_t;

  vec_t vecs [9];

  initial begin
    vecs[0] = '{8'h05, {7'h7F, 7'h7F, 7'h7F, 7'h12}};
    vecs[1] = '{8'h80, {7'h3F, 7'h79, 7'h24, 7'h00}};
    vecs[2] = '{8'h7F, {7'h7F, 7'h79, 7'h24, 7'h78}};
    vecs[3] = '{8'h64, {7'h7F, 7'h79, 7'h40, 7'h40}};
    vecs[4] = '{8'h9C, {7'h3F, 7'h79, 7'h40, 7'h40}};
    vecs[5] = '{8'h00, {7'h7F, 7'h7F, 7'h7F, 7'h40}};
    vecs[6] = '{8'hF6, {7'h3F, 7'h7F, 7'h79, 7'h40}};
    vecs[7] = '{8'hFF, {7'h3F, 7'h7F, 7'h7F, 7'h79}};
    vecs[8] = '{8'h0A, {7'h7F, 7'h7F, 7'h79, 7'h40}};

    #23;
    chk("rst_hex", {4'h0, HEX3, HEX2, HEX1, HEX0}, {4'h0, RST_DISP});
    chk("rst_busy", {31'h0, busy}, 32'd0);
    chk("rst_done", {31'h0, done}, 32'd0);
    chk("rst_AN", {28'h0, AN}, 32'hE);
    chk("rst_SEG", {25'h0, SEG}, 32'h40);
    @(negedge Clock); Clear = 1'b1;
    repeat (20) @(negedge Clock);   // full scan rotations covered by the monitor

    // vector table, back-to-back
    for (int n = 0; n < 9; n++) run(vecs[n].v, vecs[n].exp, 10'h0);

    // random loads against the arithmetic model
    for (int n = 0; n < 40; n++) begin
      automatic logic [7:0] v = 8'($urandom_range(0, 255));
      run(v, model(v), 10'h0);
    end

    // loads during CONVERT (k+3) and UPDATE (k+9) are dropped
    run(8'h05, {7'h7F, 7'h7F, 7'h7F, 7'h12}, 10'b10_0000_1000);
    @(posedge Clock); #1;
    chk("ign_done_k10", {31'h0, done}, 32'd0);
    chk("ign_busy_k10", {31'h0, busy}, 32'd0);
    repeat (10) begin
      @(posedge Clock); #1;
      chk("ign_no_done", {31'h0, done}, 32'd0);
      chk("ign_hex", {4'h0, HEX3, HEX2, HEX1, HEX0}, {4'h0, 7'h7F, 7'h7F, 7'h7F, 7'h12});
    end

    // Clear mid-conversion aborts it
    load = 1'b1; value = 8'hF6;
    @(posedge Clock); #1; load = 1'b0;
    repeat (4) @(posedge Clock);
    #1; Clear = 1'b0; mdisp = RST_DISP;
    #1;
    chk("abort_hex", {4'h0, HEX3, HEX2, HEX1, HEX0}, {4'h0, RST_DISP});
    chk("abort_busy", {31'h0, busy}, 32'd0);
    chk("abort_done", {31'h0, done}, 32'd0);
    chk("abort_AN", {28'h0, AN}, 32'hE);
    chk("abort_SEG", {25'h0, SEG}, 32'h40);
    repeat (2) @(negedge Clock);
    Clear = 1'b1;
    repeat (12) begin
      @(posedge Clock); #1;
      chk("abort_no_done", {31'h0, done}, 32'd0);
      chk("abort_busy_idle", {31'h0, busy}, 32'd0);
      chk("abort_keep", {4'h0, HEX3, HEX2, HEX1, HEX0}, {4'h0, RST_DISP});
    end
    run(8'h00, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 10'h0);
    @(posedge Clock); #1;
    chk("final_done", {31'h0, done}, 32'd0);
    repeat (20) @(negedge Clock);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
